// File: rtl/bp_resolve_queue.sv
// In-order queue of fetched conditional branches and their BHT predictions.
// Resolving the oldest entry produces a registered BHT update, a mispredict redirect and perf counts.
module bp_resolve_queue #(
    parameter int VLEN  = 64,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            push_valid_i,
    output logic            push_ready_o,
    input  logic [VLEN-1:0] push_pc_i,
    input  logic            push_pred_valid_i,
    input  logic            push_pred_taken_i,
    input  logic [VLEN-1:0] push_pred_target_i,
    input  logic            resolve_valid_i,
    input  logic            resolve_taken_i,
    input  logic [VLEN-1:0] resolve_target_i,
    output logic            bht_update_valid_o,
    output logic [VLEN-1:0] bht_update_pc_o,
    output logic            bht_update_taken_o,
    output logic            mispredict_o,
    output logic [VLEN-1:0] redirect_pc_o,
    output logic            resolve_err_o,
    output logic [31:0]     branch_cnt_o,
    output logic [31:0]     mispred_cnt_o
);

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic            taken;
        logic [VLEN-1:0] target;
    } entry_t;

    entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]     cnt_q, cnt_d;

    logic               upd_valid_q, upd_valid_d;
    logic [VLEN-1:0]    upd_pc_q, upd_pc_d;
    logic               upd_taken_q, upd_taken_d;
    logic               mis_q, mis_d;
    logic [VLEN-1:0]    redirect_q, redirect_d;
    logic               err_q, err_d;
    logic [31:0]        branch_cnt_q, branch_cnt_d;
    logic [31:0]        mispred_cnt_q, mispred_cnt_d;

    logic   full, empty, pop, push, mis;
    entry_t head_e;

    assign full         = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty        = (cnt_q == '0);
    assign push_ready_o = !full;
    assign head_e       = mem_q[head_q];

    always_comb begin
        pop  = resolve_valid_i && !empty && !flush_i;
        mis  = pop && ((head_e.taken != resolve_taken_i) ||
                       (resolve_taken_i && head_e.taken && head_e.target != resolve_target_i));
        // A mispredicting resolve squashes everything younger, including a same-cycle push.
        push = push_valid_i && !full && !flush_i && !mis;

        mem_d = mem_q;
        if (push)
            mem_d[tail_q] = '{pc: push_pc_i,
                              taken: push_pred_valid_i & push_pred_taken_i,
                              target: push_pred_target_i};

        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (flush_i || mis) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            head_d = head_q + PTR_W'(pop);
            tail_d = tail_q + PTR_W'(push);
            cnt_d  = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end

        upd_valid_d   = pop;
        upd_pc_d      = pop ? head_e.pc : upd_pc_q;
        upd_taken_d   = pop && resolve_taken_i;
        mis_d         = mis;
        redirect_d    = mis ? (resolve_taken_i ? resolve_target_i : head_e.pc + VLEN'(4))
                            : redirect_q;
        err_d         = resolve_valid_i && empty && !flush_i;
        branch_cnt_d  = branch_cnt_q + 32'(pop);
        mispred_cnt_d = mispred_cnt_q + 32'(mis);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q         <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            cnt_q         <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_taken_q   <= 1'b0;
            mis_q         <= 1'b0;
            redirect_q    <= '0;
            err_q         <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            mem_q         <= mem_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            cnt_q         <= cnt_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_taken_q   <= upd_taken_d;
            mis_q         <= mis_d;
            redirect_q    <= redirect_d;
            err_q         <= err_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bht_update_valid_o = upd_valid_q;
    assign bht_update_pc_o    = upd_pc_q;
    assign bht_update_taken_o = upd_taken_q;
    assign mispredict_o       = mis_q;
    assign redirect_pc_o      = redirect_q;
    assign resolve_err_o      = err_q;
    assign branch_cnt_o       = branch_cnt_q;
    assign mispred_cnt_o      = mispred_cnt_q;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Randomized and directed bench for bp_resolve_queue against a queue-based reference model.
module tb_bp_resolve_queue;
    localparam int VLEN  = 64;
    localparam int DEPTH = 4;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            flush_i, push_valid_i, push_ready_o;
    logic [VLEN-1:0] push_pc_i, push_pred_target_i, resolve_target_i;
    logic            push_pred_valid_i, push_pred_taken_i;
    logic            resolve_valid_i, resolve_taken_i;
    logic            bht_update_valid_o, bht_update_taken_o, mispredict_o, resolve_err_o;
    logic [VLEN-1:0] bht_update_pc_o, redirect_pc_o;
    logic [31:0]     branch_cnt_o, mispred_cnt_o;

    bp_resolve_queue #(.VLEN(VLEN), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .push_valid_i(push_valid_i), .push_ready_o(push_ready_o), .push_pc_i(push_pc_i),
        .push_pred_valid_i(push_pred_valid_i), .push_pred_taken_i(push_pred_taken_i),
        .push_pred_target_i(push_pred_target_i),
        .resolve_valid_i(resolve_valid_i), .resolve_taken_i(resolve_taken_i),
        .resolve_target_i(resolve_target_i),
        .bht_update_valid_o(bht_update_valid_o), .bht_update_pc_o(bht_update_pc_o),
        .bht_update_taken_o(bht_update_taken_o), .mispredict_o(mispredict_o),
        .redirect_pc_o(redirect_pc_o), .resolve_err_o(resolve_err_o),
        .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [VLEN-1:0] pc;
        bit              eff;
        logic [VLEN-1:0] tgt;
    } ent_t;

    ent_t            q[$];
    bit              e_uv, e_ut, e_mis, e_err;
    logic [VLEN-1:0] e_upc, e_rpc;
    logic [31:0]     e_bc, e_mc;
    int              total = 0;
    int              bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        e_uv = 0; e_ut = 0; e_mis = 0; e_err = 0;
        e_upc = '0; e_rpc = '0; e_bc = '0; e_mc = '0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, 64'(push_ready_o), 64'd1);
        chk({tag, "_uv"},    64'(bht_update_valid_o), 64'd0);
        chk({tag, "_upc"},   bht_update_pc_o, 64'd0);
        chk({tag, "_ut"},    64'(bht_update_taken_o), 64'd0);
        chk({tag, "_mis"},   64'(mispredict_o), 64'd0);
        chk({tag, "_rpc"},   redirect_pc_o, 64'd0);
        chk({tag, "_err"},   64'(resolve_err_o), 64'd0);
        chk({tag, "_bc"},    64'(branch_cnt_o), 64'd0);
        chk({tag, "_mc"},    64'(mispred_cnt_o), 64'd0);
    endtask

    task automatic idle_inputs();
        flush_i = 0; push_valid_i = 0; push_pc_i = '0; push_pred_valid_i = 0;
        push_pred_taken_i = 0; push_pred_target_i = '0;
        resolve_valid_i = 0; resolve_taken_i = 0; resolve_target_i = '0;
    endtask

    // One cycle: drive, predict from the model, clock, compare every output.
    task automatic step(input bit pv, input logic [63:0] pc, input bit pdv, input bit pdt,
                        input logic [63:0] ptg, input bit rv, input bit rt,
                        input logic [63:0] rtg, input bit fl);
        bit   was_full, mis;
        ent_t h;
        push_valid_i = pv; push_pc_i = pc; push_pred_valid_i = pdv; push_pred_taken_i = pdt;
        push_pred_target_i = ptg; resolve_valid_i = rv; resolve_taken_i = rt;
        resolve_target_i = rtg; flush_i = fl;
        #1;
        was_full = (q.size() == DEPTH);
        chk("push_ready", 64'(push_ready_o), 64'(!was_full));
        e_uv = 0; e_ut = 0; e_mis = 0; e_err = 0; mis = 0;
        if (fl) begin
            q.delete();
        end else begin
            if (rv) begin
                if (q.size() == 0) e_err = 1;
                else begin
                    h = q.pop_front();
                    e_uv = 1; e_upc = h.pc; e_ut = rt; e_bc++;
                    mis = (h.eff != rt) || (rt && h.eff && h.tgt != rtg);
                    if (mis) begin
                        e_mis = 1; e_mc++;
                        e_rpc = rt ? rtg : h.pc + 64'd4;
                        q.delete();
                    end
                end
            end
            if (pv && !was_full && !mis) q.push_back('{pc: pc, eff: pdv && pdt, tgt: ptg});
        end
        @(posedge clk_i); #1;
        chk("upd_valid", 64'(bht_update_valid_o), 64'(e_uv));
        if (e_uv) chk("upd_pc", bht_update_pc_o, e_upc);
        chk("upd_taken", 64'(bht_update_taken_o), 64'(e_ut));
        chk("mispredict", 64'(mispredict_o), 64'(e_mis));
        chk("redirect_pc", redirect_pc_o, e_rpc);
        chk("resolve_err", 64'(resolve_err_o), 64'(e_err));
        chk("branch_cnt", 64'(branch_cnt_o), 64'(e_bc));
        chk("mispred_cnt", 64'(mispred_cnt_o), 64'(e_mc));
        idle_inputs();
    endtask

    task automatic push_br(input logic [63:0] pc, input bit pdv, input bit pdt, input logic [63:0] ptg);
        step(1, pc, pdv, pdt, ptg, 0, 0, '0, 0);
    endtask

    task automatic resolve(input bit rt, input logic [63:0] rtg);
        step(0, '0, 0, 0, '0, 1, rt, rtg, 0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1;
        repeat (2) @(posedge clk_i);
        #1;
        model_reset();
        chk_idle_outputs("reset");
        rst_i = 0;
    endtask

    logic [31:0] bc_save, mc_save;

    initial begin
        idle_inputs();
        do_reset();

        // Correct taken prediction
        push_br(64'h1000, 1, 1, 64'h2000);
        resolve(1, 64'h2000);
        chk("t1_uv", 64'(bht_update_valid_o), 64'd1);
        chk("t1_pc", bht_update_pc_o, 64'h1000);
        chk("t1_taken", 64'(bht_update_taken_o), 64'd1);
        chk("t1_mis", 64'(mispredict_o), 64'd0);
        chk("t1_bc", 64'(branch_cnt_o), 64'd1);
        chk("t1_mc", 64'(mispred_cnt_o), 64'd0);

        // BHT miss counts as not-taken
        push_br(64'h1000, 0, 1, 64'h9999);
        resolve(1, 64'h1800);
        chk("t2_mis", 64'(mispredict_o), 64'd1);
        chk("t2_rpc", redirect_pc_o, 64'h1800);
        chk("t2_mc", 64'(mispred_cnt_o), 64'd1);

        // Mispredict flushes younger entries
        push_br(64'h100, 1, 1, 64'h400);
        push_br(64'h200, 1, 1, 64'h400);
        push_br(64'h300, 1, 1, 64'h400);
        resolve(0, '0);
        chk("t3_rpc", redirect_pc_o, 64'h104);
        chk("t3_mis", 64'(mispredict_o), 64'd1);
        resolve(0, '0);
        chk("t3_err", 64'(resolve_err_o), 64'd1);
        chk("t3_uv", 64'(bht_update_valid_o), 64'd0);

        // Full queue, dropped 5th push, push+resolve across tail wrap
        push_br(64'h10, 0, 0, '0);
        push_br(64'h20, 0, 0, '0);
        push_br(64'h30, 0, 0, '0);
        push_br(64'h40, 0, 0, '0);
        chk("t4_full", 64'(push_ready_o), 64'd0);
        push_br(64'h50, 0, 0, '0);
        resolve(0, '0);
        chk("t4_pop1", bht_update_pc_o, 64'h10);
        step(1, 64'h60, 0, 0, '0, 1, 0, '0, 0);
        chk("t4_pop2", bht_update_pc_o, 64'h20);
        chk("t4_ready3", 64'(push_ready_o), 64'd1);
        resolve(0, '0);
        chk("t4_pop3", bht_update_pc_o, 64'h30);
        resolve(0, '0);
        chk("t4_pop4", bht_update_pc_o, 64'h40);
        resolve(0, '0);
        chk("t4_pop5", bht_update_pc_o, 64'h60);

        // Target mismatch
        push_br(64'h500, 1, 1, 64'h2000);
        resolve(1, 64'h3000);
        chk("t5_mis", 64'(mispredict_o), 64'd1);
        chk("t5_rpc", redirect_pc_o, 64'h3000);
        chk("t5_taken", 64'(bht_update_taken_o), 64'd1);

        // pc+4 wraps at the top of the address space
        push_br(64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 64'h2000);
        resolve(0, '0);
        chk("wrap_rpc", redirect_pc_o, 64'h0);

        // flush beats same-cycle push and resolve
        push_br(64'h700, 0, 0, '0);
        bc_save = branch_cnt_o; mc_save = mispred_cnt_o;
        step(1, 64'h800, 1, 1, 64'h900, 1, 1, 64'h123, 1);
        chk("t6_uv", 64'(bht_update_valid_o), 64'd0);
        chk("t6_mis", 64'(mispredict_o), 64'd0);
        chk("t6_bc", 64'(branch_cnt_o), 64'(bc_save));
        chk("t6_mc", 64'(mispred_cnt_o), 64'(mc_save));
        resolve(0, '0);
        chk("t6_empty_err", 64'(resolve_err_o), 64'd1);

        // Asynchronous reset mid-stream, between clock edges
        push_br(64'hA00, 1, 0, '0);
        push_br(64'hB00, 1, 1, 64'hC00);
        step(0, '0, 0, 0, '0, 1, 1, 64'hD00, 0);
        #2 rst_i = 1;
        #1;
        model_reset();
        chk_idle_outputs("midrst");
        @(posedge clk_i); #1;
        rst_i = 0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] pc;
            pc = ($urandom_range(0, 31) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                              : 64'($urandom_range(0, 1023)) << 2;
            step($urandom_range(0, 9) < 6, pc, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                 $urandom_range(0, 1) != 0 ? 64'h2000 : 64'h3000,
                 $urandom_range(0, 9) < 4, $urandom_range(0, 1) != 0,
                 $urandom_range(0, 1) != 0 ? 64'h2000 : 64'h3000,
                 $urandom_range(0, 39) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
